// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - WISC-15 control package: opcodes, ALU commands, control bundle
package ctrl_pkg;

    localparam int CMD_W = 4;
    localparam int RD_W  = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_PADDSB = 4'd1,  OP_SUB = 4'd2,  OP_NAND = 4'd3,
        OP_XOR  = 4'd4,  OP_SLL    = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7,
        OP_LW   = 4'd8,  OP_SW     = 4'd9,  OP_LHB = 4'd10, OP_LLB  = 4'd11,
        OP_B    = 4'd12, OP_CALL   = 4'd13, OP_RET = 4'd14, OP_HLT  = 4'd15
    } opcode_e;

    localparam logic [CMD_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [CMD_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [CMD_W-1:0] ALU_PADDSB = 4'b0010;
    localparam logic [CMD_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [CMD_W-1:0] ALU_NAND   = 4'b1000;
    localparam logic [CMD_W-1:0] ALU_SLL    = 4'b1100;
    localparam logic [CMD_W-1:0] ALU_SRL    = 4'b1110;
    localparam logic [CMD_W-1:0] ALU_SRA    = 4'b1111;

    typedef struct packed {
        logic [CMD_W-1:0] alu_cmd;
        logic             set_over;
        logic             set_zero;
        logic             branch;
        logic             mem_wrt;
        logic             mem_to_reg;
        logic             reg_wrt;
        logic             halt;
        logic [RD_W-1:0]  rd;
        logic             valid;
    } ctrl_bundle_t;

    // Register-register ALU ops and SW read the rt field.
    function automatic logic uses_rt(input logic [3:0] op);
        return (op <= 4'd7) || (op == 4'd9);
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID inputs and stage-aligned control outputs; perf counters under CTRL_PIPE_PERF_EN
interface ctrl_pipe_if #(
    parameter int OP_W      = 4,
    parameter int ALU_CMD_W = 4,
    parameter int REG_W     = 4
);
    logic [OP_W-1:0]      id_op;
    logic                 id_valid;
    logic [REG_W-1:0]     id_rd;
    logic [REG_W-1:0]     id_rs;
    logic [REG_W-1:0]     id_rt;
    logic                 stall;
    logic                 flush;
    logic                 hazard_stall;
    logic                 ex_valid;
    logic [ALU_CMD_W-1:0] ex_alu_cmd;
    logic                 ex_set_over;
    logic                 ex_set_zero;
    logic                 ex_branch;
    logic                 mem_valid;
    logic                 mem_wrt;
    logic                 mem_to_reg;
    logic                 wb_valid;
    logic                 wb_reg_wrt;
    logic                 wb_mem_to_reg;
    logic [REG_W-1:0]     wb_rd;
    logic                 halted;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]          perf_retired;
    logic [31:0]          perf_bubbles;
`endif

    modport master (
        output id_op, id_valid, id_rd, id_rs, id_rt, stall, flush,
        input  hazard_stall, ex_valid, ex_alu_cmd, ex_set_over, ex_set_zero, ex_branch,
        input  mem_valid, mem_wrt, mem_to_reg,
        input  wb_valid, wb_reg_wrt, wb_mem_to_reg, wb_rd, halted
`ifdef CTRL_PIPE_PERF_EN
        , input perf_retired, perf_bubbles
`endif
    );

    modport slave (
        input  id_op, id_valid, id_rd, id_rs, id_rt, stall, flush,
        output hazard_stall, ex_valid, ex_alu_cmd, ex_set_over, ex_set_zero, ex_branch,
        output mem_valid, mem_wrt, mem_to_reg,
        output wb_valid, wb_reg_wrt, wb_mem_to_reg, wb_rd, halted
`ifdef CTRL_PIPE_PERF_EN
        , output perf_retired, perf_bubbles
`endif
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control bundle decoder (valid=1 for legal codes)
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output ctrl_bundle_t    ctrl
);

    always_comb begin
        ctrl = '0;
        // Codes above the low 16 stay an all-zero bubble.
        if (int'(op) < 16) begin
            ctrl.valid = 1'b1;
            case (op[3:0])
                OP_ADD:    begin ctrl.alu_cmd = ALU_ADD;  ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_PADDSB: begin ctrl.alu_cmd = ALU_PADDSB; ctrl.reg_wrt = 1'b1; end
                OP_SUB:    begin ctrl.alu_cmd = ALU_SUB;  ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_NAND:   begin ctrl.alu_cmd = ALU_NAND; ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_XOR:    begin ctrl.alu_cmd = ALU_XOR;  ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_SLL:    begin ctrl.alu_cmd = ALU_SLL;  ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_SRL:    begin ctrl.alu_cmd = ALU_SRL;  ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_SRA:    begin ctrl.alu_cmd = ALU_SRA;  ctrl.set_zero = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_LW:     begin ctrl.reg_wrt = 1'b1; ctrl.mem_to_reg = 1'b1; end
                OP_SW:     ctrl.mem_wrt = 1'b1;
                OP_LHB:    ctrl.reg_wrt = 1'b1;
                OP_LLB:    ctrl.reg_wrt = 1'b1;
                OP_B:      ctrl.branch = 1'b1;
                OP_CALL:   begin ctrl.branch = 1'b1; ctrl.reg_wrt = 1'b1; end
                OP_RET:    ctrl.branch = 1'b1;
                OP_HLT:    ctrl.halt = 1'b1;
                default:   ctrl.valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX/MEM/WB control pipeline with load-use hazard, stall, flush, halt; CTRL_PIPE_PERF_EN adds perf counters
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int ALU_CMD_W = 4,
    parameter int REG_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);

    ctrl_bundle_t id_dec;
    ctrl_bundle_t id_ctrl;
    ctrl_bundle_t ex_q;
    ctrl_bundle_t mem_q;
    ctrl_bundle_t wb_q;
    logic         halt_seen;
    logic         halted_q;
    logic         rt_used;
    logic         hazard;
    logic         take_id;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op   (bus.id_op),
        .ctrl (id_dec)
    );

    // After HLT has entered EX, ID is ignored so only bubbles follow it.
    assign take_id = id_dec.valid && bus.id_valid && !halt_seen;

    always_comb begin
        id_ctrl = '0;
        if (take_id) begin
            id_ctrl    = id_dec;
            id_ctrl.rd = id_dec.reg_wrt ? RD_W'(bus.id_rd) : '0;
        end
    end

    assign rt_used = id_dec.valid && uses_rt(bus.id_op[3:0]);
    assign hazard  = ex_q.valid && ex_q.mem_to_reg && (ex_q.rd != '0) &&
                     ((ex_q.rd == RD_W'(bus.id_rs)) || ((ex_q.rd == RD_W'(bus.id_rt)) && rt_used));

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            halt_seen <= 1'b0;
            halted_q  <= 1'b0;
        end else if (!bus.stall) begin
            ex_q  <= (hazard || bus.flush) ? '0 : id_ctrl;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (!hazard && !bus.flush && id_ctrl.halt) begin
                halt_seen <= 1'b1;
            end
            if (mem_q.valid && mem_q.halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.hazard_stall  = hazard;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_cmd    = ALU_CMD_W'(ex_q.alu_cmd);
    assign bus.ex_set_over   = ex_q.set_over;
    assign bus.ex_set_zero   = ex_q.set_zero;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.mem_valid     = mem_q.valid;
    assign bus.mem_wrt       = mem_q.mem_wrt;
    assign bus.mem_to_reg    = mem_q.mem_to_reg;
    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_reg_wrt    = wb_q.reg_wrt;
    assign bus.wb_mem_to_reg = wb_q.mem_to_reg;
    assign bus.wb_rd         = REG_W'(wb_q.rd);
    assign bus.halted        = halted_q;

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.alu_cmd, wb_q.set_over, wb_q.set_zero, wb_q.branch, wb_q.mem_wrt, wb_q.halt};

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            bubbles_q <= '0;
        end else if (!bus.stall && !halted_q) begin
            if (wb_q.valid) begin
                retired_q <= retired_q + 32'd1;
            end else begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign bus.perf_retired = retired_q;
    assign bus.perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe with decode table and stage scoreboards
module tb_ctrl_pipe;

    typedef struct {
        logic [3:0] alu;
        logic       ov;
        logic       zr;
        logic       br;
        logic       mw;
        logic       m2r;
        logic       rw;
        logic [3:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.OP_W(4), .ALU_CMD_W(4), .REG_W(4)) bus ();

    ctrl_pipe #(.OP_W(4), .ALU_CMD_W(4), .REG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t dec_tab [16];
    vec_t ex_q [$];
    vec_t mem_q [$];
    vec_t wb_q [$];
    logic mon_en = 1'b0;
    logic last_stall = 1'b0;

    logic       m_ex_lw, m_halt_seen, m_halted;
    logic [3:0] m_ex_rd;
    logic       m_ex_v, m_ex_h, m_mem_v, m_mem_h, m_wb_v, m_wb_h;
    int         m_ret, m_bub;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic acc, input logic is_halt);
        if (!st) begin
            if (!m_halted) begin
                if (m_wb_v) m_ret++;
                else        m_bub++;
            end
            if (m_mem_v && m_mem_h) m_halted = 1'b1;
            m_wb_v  = m_mem_v; m_wb_h  = m_mem_h;
            m_mem_v = m_ex_v;  m_mem_h = m_ex_h;
            m_ex_v  = acc;     m_ex_h  = acc && is_halt;
        end
    endtask

    task automatic model_reset();
        m_ex_lw = 0; m_ex_rd = 0; m_halt_seen = 0; m_halted = 0;
        m_ex_v = 0; m_ex_h = 0; m_mem_v = 0; m_mem_h = 0; m_wb_v = 0; m_wb_h = 0;
        m_ret = 0; m_bub = 0;
    endtask

    // One clock: drive after the edge, check hazard, record what the next edge accepts.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic st, input logic fl, output logic acc);
        logic hz;
        vec_t e;
        @(posedge clk); #1;
        bus.id_valid = v; bus.id_op = op; bus.id_rd = rd; bus.id_rs = rs; bus.id_rt = rt;
        bus.stall = st; bus.flush = fl;
        hz = m_ex_lw && (m_ex_rd != 4'd0) &&
             ((m_ex_rd == rs) || ((m_ex_rd == rt) && ((op <= 4'd7) || (op == 4'd9))));
        @(negedge clk); #1;
        check("hazard_stall", bus.hazard_stall, hz);
        acc = v && !st && !hz && !fl && !m_halt_seen;
        if (!st) begin
            m_ex_lw = acc && (op == 4'd8);
            m_ex_rd = acc ? rd : 4'd0;
            if (acc && op == 4'd15) m_halt_seen = 1'b1;
        end
        if (acc) begin
            e = dec_tab[op];
            e.rd = e.rw ? rd : 4'd0;
            ex_q.push_back(e); mem_q.push_back(e); wb_q.push_back(e);
        end
        model_edge(st, acc, op == 4'd15);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt, output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 4) begin
            cyc(1'b1, op, rd, rs, rt, 1'b0, 1'b0, acc);
            tries++;
        end
        check("issue_accepted", acc, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        mon_en = 1'b0; rst = 1'b1;
        bus.id_valid = 0; bus.id_op = 0; bus.id_rd = 0; bus.id_rs = 0; bus.id_rt = 0;
        bus.stall = 0; bus.flush = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valids", {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.halted, bus.hazard_stall}, 0);
        check("rst_ctrl", {bus.ex_alu_cmd, bus.ex_set_over, bus.ex_set_zero, bus.ex_branch, bus.mem_wrt,
                           bus.mem_to_reg, bus.wb_reg_wrt, bus.wb_mem_to_reg, bus.wb_rd}, 0);
`ifdef CTRL_PIPE_PERF_EN
        check("rst_perf", bus.perf_retired | bus.perf_bubbles, 0);
`endif
        #1;
        rst = 1'b0;
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        model_reset();
        model_edge(1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
    endtask

    always @(posedge clk) last_stall <= bus.stall;

    always @(negedge clk) begin : monitor
        vec_t e;
        if (mon_en && !rst && !last_stall) begin
            if (bus.ex_valid) begin
                if (ex_q.size() == 0) check("ex_unexpected", 1, 0);
                else begin
                    e = ex_q.pop_front();
                    check("ex_ctrl", {bus.ex_alu_cmd, bus.ex_set_over, bus.ex_set_zero, bus.ex_branch},
                          {e.alu, e.ov, e.zr, e.br});
                end
            end else check("ex_bubble", {bus.ex_alu_cmd, bus.ex_set_over, bus.ex_set_zero, bus.ex_branch}, 0);
            if (bus.mem_valid) begin
                if (mem_q.size() == 0) check("mem_unexpected", 1, 0);
                else begin
                    e = mem_q.pop_front();
                    check("mem_ctrl", {bus.mem_wrt, bus.mem_to_reg}, {e.mw, e.m2r});
                end
            end else check("mem_bubble", {bus.mem_wrt, bus.mem_to_reg}, 0);
            if (bus.wb_valid) begin
                if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
                else begin
                    e = wb_q.pop_front();
                    check("wb_ctrl", {bus.wb_reg_wrt, bus.wb_mem_to_reg, bus.wb_rd}, {e.rw, e.m2r, e.rd});
                end
            end else check("wb_bubble", {bus.wb_reg_wrt, bus.wb_mem_to_reg, bus.wb_rd}, 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   tries;
        logic acc;
`ifdef CTRL_PIPE_PERF_EN
        logic [31:0] r_snap, b_snap;
`endif
        //                alu      ov zr br mw m2r rw rd
        dec_tab[0]  = '{4'b0000, 1, 1, 0, 0, 0, 1, 0};
        dec_tab[1]  = '{4'b0010, 0, 0, 0, 0, 0, 1, 0};
        dec_tab[2]  = '{4'b0001, 1, 1, 0, 0, 0, 1, 0};
        dec_tab[3]  = '{4'b1000, 0, 1, 0, 0, 0, 1, 0};
        dec_tab[4]  = '{4'b0100, 0, 1, 0, 0, 0, 1, 0};
        dec_tab[5]  = '{4'b1100, 0, 1, 0, 0, 0, 1, 0};
        dec_tab[6]  = '{4'b1110, 0, 1, 0, 0, 0, 1, 0};
        dec_tab[7]  = '{4'b1111, 0, 1, 0, 0, 0, 1, 0};
        dec_tab[8]  = '{4'b0000, 0, 0, 0, 0, 1, 1, 0};
        dec_tab[9]  = '{4'b0000, 0, 0, 0, 1, 0, 0, 0};
        dec_tab[10] = '{4'b0000, 0, 0, 0, 0, 0, 1, 0};
        dec_tab[11] = '{4'b0000, 0, 0, 0, 0, 0, 1, 0};
        dec_tab[12] = '{4'b0000, 0, 0, 1, 0, 0, 0, 0};
        dec_tab[13] = '{4'b0000, 0, 0, 1, 0, 0, 1, 0};
        dec_tab[14] = '{4'b0000, 0, 0, 1, 0, 0, 0, 0};
        dec_tab[15] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0};
        model_reset();
        do_reset();

        // ADD latency: EX after one edge, WB after three.
        issue(4'd0, 4'd6, 4'd1, 4'd2, tries);
        idle(1);
        check("add_ex", {bus.ex_valid, bus.ex_alu_cmd, bus.ex_set_over, bus.ex_set_zero}, {1'b1, 4'b0000, 1'b1, 1'b1});
        idle(1);
        check("add_mem_valid", bus.mem_valid, 1'b1);
        idle(1);
        check("add_wb", {bus.wb_valid, bus.wb_reg_wrt, bus.wb_rd}, {1'b1, 1'b1, 4'd6});

        // Decode table sweep, back to back.
        for (int op = 0; op < 15; op++) issue(4'(op), 4'(op), 4'd1, 4'd2, tries);
        idle(4);

        // Load-use hazard, then the same pattern with rd=0.
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd4, tries);
        issue(4'd8, 4'd3, 4'd1, 4'd2, tries);
        issue(4'd2, 4'd5, 4'd3, 4'd1, tries);
        check("hazard_one_cycle", tries, 2);
        issue(4'd4, 4'd6, 4'd1, 4'd2, tries);
        issue(4'd9, 4'd0, 4'd1, 4'd2, tries);
        idle(4);
`ifdef CTRL_PIPE_PERF_EN
        check("perf_retired", bus.perf_retired, 5);
        check("perf_retired_model", bus.perf_retired, m_ret);
        check("perf_bubbles", bus.perf_bubbles, m_bub);
`endif
        issue(4'd8, 4'd0, 4'd1, 4'd2, tries);
        issue(4'd2, 4'd5, 4'd0, 4'd0, tries);
        check("no_hazard_rd0", tries, 1);
        issue(4'd8, 4'd7, 4'd1, 4'd2, tries);
        issue(4'd9, 4'd0, 4'd1, 4'd7, tries);
        check("hazard_rt_sw", tries, 2);
        issue(4'd8, 4'd7, 4'd1, 4'd2, tries);
        issue(4'd10, 4'd1, 4'd2, 4'd7, tries);
        check("no_hazard_rt_unused", tries, 1);
        idle(3);

        // Flush with B in EX discards XOR in ID.
        issue(4'd12, 4'd0, 4'd1, 4'd2, tries);
        cyc(1'b1, 4'd4, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1, acc);
        check("flush_b_in_ex", {bus.ex_valid, bus.ex_branch}, 2'b11);
        idle(1);
        check("flush_ex_bubble", bus.ex_valid, 1'b0);
        idle(3);

        // Three stalled edges with SW in MEM.
        issue(4'd9, 4'd0, 4'd1, 4'd2, tries);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
            check("stall_mem_wrt", {bus.mem_valid, bus.mem_wrt}, 2'b11);
        end
        idle(1);
        check("stall_mem_wrt_held", {bus.mem_valid, bus.mem_wrt}, 2'b11);
        idle(1);
        check("stall_release", {bus.mem_valid, bus.wb_valid}, 2'b01);
        idle(3);

        // Reset mid-operation drops everything.
        issue(4'd0, 4'd1, 4'd2, 4'd3, tries);
        issue(4'd8, 4'd5, 4'd2, 4'd3, tries);
        idle(1);
        do_reset();

        // Halt: following ADD ignored, halted after third edge, sticky.
        issue(4'd15, 4'd0, 4'd1, 4'd2, tries);
        cyc(1'b1, 4'd0, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0, acc);
        check("halt_add_ignored", acc, 1'b0);
        idle(1);
        check("halted_early", bus.halted, 1'b0);
        check("halt_ex_bubble", bus.ex_valid, 1'b0);
        idle(1);
        check("halted_set", {bus.halted, bus.wb_valid}, 2'b11);
`ifdef CTRL_PIPE_PERF_EN
        r_snap = bus.perf_retired;
        b_snap = bus.perf_bubbles;
`endif
        cyc(1'b1, 4'd0, 4'd4, 4'd1, 4'd2, 1'b0, 1'b1, acc);
        idle(3);
        check("halted_sticky", {bus.halted, bus.ex_valid}, 2'b10);
`ifdef CTRL_PIPE_PERF_EN
        check("perf_frozen_ret", bus.perf_retired, r_snap);
        check("perf_frozen_bub", bus.perf_bubbles, b_snap);
        check("perf_frozen_model", bus.perf_bubbles, m_bub);
`endif
        check("sb_drained", ex_q.size() + mem_q.size() + wb_q.size(), 0);
        do_reset();
        check("halted_cleared", bus.halted, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined, parametrised control unit for the WISC-15 core. It decodes the opcode presented in ID and carries the resulting control bundle through registered EX, MEM and WB stages. It detects load-use hazards, and honours external stall and flush requests. It latches a sticky halt once a `hlt` instruction retires. The block sits between the instruction register and the datapath, and replaces per-cycle combinational control with stage-aligned control.

## Interface
Parameters:
- OP_W, 4, opcode width; the decoded opcodes occupy the low 16 codes, and any higher code decodes as a NOP bubble.
- ALU_CMD_W, 4, ALU command width.
- REG_W, 4, register-specifier width.

Ports (clock and reset first):
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_op  in  OP_W  opcode of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rd / id_rs / id_rt  in  REG_W  destination and source specifiers in ID.
- stall  in  1  external freeze of all stages (memory wait).
- flush  in  1  kill the ID instruction (taken branch/call/ret resolved in EX).
- hazard_stall  out  1  combinational; a load-use hazard holds ID.
- ex_valid, ex_alu_cmd[ALU_CMD_W], ex_set_over, ex_set_zero, ex_branch  out  EX-stage control.
- mem_valid, mem_wrt, mem_to_reg  out  MEM-stage control.
- wb_valid, wb_reg_wrt, wb_mem_to_reg, wb_rd[REG_W]  out  WB-stage control.
- halted  out  1  sticky; set when `hlt` retires from WB.

## Operation
Decode map (opcode → ALU command / flags):
- 0 ADD → 0000, sets over and zero; 1 PADDSB → 0010; 2 SUB → 0001, sets over and zero.
- 3 NAND → 1000, sets zero; 4 XOR → 0100, sets zero; 5 SLL → 1100, sets zero; 6 SRL → 1110, sets zero; 7 SRA → 1111, sets zero.
- Opcodes 0–7 have reg_wrt=1.
- 8 LW: reg_wrt=1, mem_to_reg=1. 9 SW: mem_wrt=1. 10 LHB / 11 LLB: reg_wrt=1.
- 12 B, 14 RET: branch=1. 13 CALL: branch=1, reg_wrt=1. 15 HLT: halt bit, which is carried internally.

Fields a stage does not use are 0.

Advance rules (priority: rst > stall > hazard_stall > flush > normal):
- **rst:** all valid bits 0, all control outputs 0, halted 0, halt_seen 0.
- **stall:** every stage register holds its value.
- **hazard_stall = 1** when all of the following hold: ex_valid, EX holds LW, ex_rd is nonzero, and ex_rd equals id_rs or (id_rt and the ID opcode reads rt, i.e. opcodes 0–7 and 9). EX then receives a bubble (valid=0, all control 0). MEM and WB advance.
- **flush:** EX receives a bubble, and the ID instruction is discarded.
- **normal:** ID→EX→MEM→WB shift. Control fields in a stage with valid=0 are forced to 0.

Halt handling:
- halt_seen sets when a valid HLT enters EX.
- While halt_seen is 1, id_valid is ignored, so only bubbles enter EX. A later flush clears nothing.
- halted sets when a valid HLT is in WB, and stays set until rst.

## Timing
- An instruction presented in ID at edge n appears on the EX outputs after edge n+1, on MEM after n+2, and on WB after n+3.
- A stall inserts whole cycles of extra latency.
- hazard_stall is combinational from id_* and the EX registers within the same cycle. It stalls exactly one cycle per LW-use pair.
- stall together with flush: stall wins. The flush must be re-asserted by its source in the next non-stall cycle.
- rst mid-operation: every in-flight instruction is dropped in one edge.

## Configuration
- **CTRL_PIPE_PERF_EN:**
  - When defined, adds outputs perf_retired[31:0] and perf_bubbles[31:0]. perf_retired increments on each valid WB cycle without stall. perf_bubbles increments on each non-stall cycle with WB valid=0.
  - Both counters wrap at 2^32, clear on rst, and freeze when halted=1.
- When the macro is undefined, these ports and counters do not exist.

## Structure
- Shared package ctrl_pkg: opcode constants, ALU command constants, the packed ctrl_bundle_t struct (alu_cmd, set_over, set_zero, branch, mem_wrt, mem_to_reg, reg_wrt, halt, rd, valid), and the uses_rt() function.
- Sub-module ctrl_decode: purely combinational, op → ctrl_bundle_t. It is instantiated once in ID. Stage registers live in ctrl_pipe.

## Test plan
- **Reset and ALU decode:** ADD (op 0) with valid=1 at edge 1 → EX shows alu_cmd=0000, set_over=1, set_zero=1 after edge 1; wb_reg_wrt=1 after edge 3.
- **Load-use hazard:** LW rd=3, then SUB rs=3 → hazard_stall=1 for one cycle, an EX bubble, and SUB reaches EX one cycle late. Repeat with rd=0 → no stall.
- **Flush:** valid B in EX with flush=1 while XOR is in ID → XOR never reaches EX (ex_valid=0 next cycle).
- **Stall:** stall=1 for 3 cycles with SW in MEM → mem_wrt stays 1, and all stages hold.
- **Halt:** HLT followed by ADD with valid=1 → ADD ignored; halted=1 three edges after HLT enters ID; it stays 1 until rst, and clears on rst.
- **Perf counters (CTRL_PIPE_PERF_EN):** 5 instructions plus 1 hazard bubble → perf_retired=5, perf_bubbles counted exactly.
